// File: rtl/fetch_pkg.sv
// Fetch stage shared types and constants.
// Widths, reset PC, NOP encoding and PC stride.
package fetch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INSTR_W = 32;
  localparam logic [7:0] DEF_RESET_PC = 8'h00;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;
  localparam int CNT_W = 16;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: ROM port, redirect, decode handshake.
// master = fetch stage, slave = surrounding core/bench.
interface fetch_if #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               misalign_err;
  logic [15:0]        fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  misalign_err,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output slice toward decode.
// Flush kills valid but keeps the payload.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Flush beats load; otherwise capture or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM address, output slice,
// redirect flush, misalign pulse, transfer counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic   clk,
  input logic   rst_n,
  fetch_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic              advance;
  logic              load;
  logic              xfer;
  logic [ADDR_W-1:0] tgt;

  assign advance = !bus.out_valid || bus.out_ready;
  assign load = !bus.redirect_valid && advance;
  assign xfer = bus.out_valid && bus.out_ready;
  assign tgt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign bus.imem_addr = pc;

  // Program counter: redirect, step, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= tgt;
    end else if (advance) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  // One-cycle pulse for a misaligned redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.misalign_err <= 1'b0;
    end else begin
      bus.misalign_err <= bus.redirect_valid
                          && |bus.redirect_pc[1:0];
    end
  end

  // Saturating count of decode handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fetch_count <= '0;
    end else if (xfer && bus.fetch_count != '1) begin
      bus.fetch_count <= bus.fetch_count + 16'd1;
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.redirect_valid),
    .load   (load),
    .d_instr(bus.imem_data),
    .d_pc   (pc),
    .valid  (bus.out_valid),
    .instr  (bus.out_instr),
    .pc     (bus.out_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed program walk plus
// random ready/redirect traffic against a model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;

  logic [31:0] rom [64];

  fetch_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

  fetch_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imem_data = rom[bus.imem_addr[7:2]];

  always #5 clk = ~clk;

  int m_pc, m_opc, m_cnt;
  bit m_v, m_mis;
  logic [31:0] m_instr;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_opc = 0;
    m_cnt = 0;
    m_v = 0;
    m_mis = 0;
    m_instr = 32'h0000_0013;
  endtask

  task automatic compare(string ph);
    check({ph, ".addr"}, 32'(bus.imem_addr), 32'(m_pc));
    check({ph, ".valid"}, 32'(bus.out_valid), 32'(m_v));
    check({ph, ".opc"}, 32'(bus.out_pc), 32'(m_opc));
    check({ph, ".instr"}, bus.out_instr, m_instr);
    check({ph, ".mis"}, 32'(bus.misalign_err), 32'(m_mis));
    check({ph, ".cnt"}, 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  // Predict from current inputs, clock once, compare.
  task automatic step(string ph);
    bit rdy, rv;
    int rpc;
    rdy = bus.out_ready;
    rv = bus.redirect_valid;
    rpc = int'(bus.redirect_pc);
    if (m_v && rdy && m_cnt < 65535) m_cnt++;
    if (rv) begin
      m_pc = rpc - (rpc % 4);
      m_v = 0;
      m_mis = (rpc % 4) != 0;
    end else if (!m_v || rdy) begin
      m_instr = rom[m_pc / 4];
      m_opc = m_pc;
      m_v = 1;
      m_pc = (m_pc + 4) % 256;
      m_mis = 0;
    end else begin
      m_mis = 0;
    end
    @(posedge clk);
    #1;
    compare(ph);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0ff0_0083;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h0020_f1b3;
    rom[3] = 32'h0030_23b3;
    rom[5] = 32'hfe00_06e3;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("run0");
    check("run0.pc", 32'(bus.out_pc), 32'h00);
    check("run0.ins", bus.out_instr, 32'h0ff0_0083);
    step("run1");
    check("run1.ins", bus.out_instr, 32'h0010_0113);
    check("run1.addr", 32'(bus.imem_addr), 32'h08);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.cnt", 32'(bus.fetch_count), 32'd1);
    bus.out_ready = 1'b1;
    step("resume");
    check("resume.ins", bus.out_instr, 32'h0020_f1b3);
    for (int i = 0; i < 3; i++) step("walk");
    check("walk.ins", bus.out_instr, 32'hfe00_06e3);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h00;
    step("redir");
    check("redir.cnt", 32'(bus.fetch_count), 32'd6);
    bus.redirect_valid = 1'b0;
    step("redir.tgt");
    check("redir.ins", bus.out_instr, 32'h0ff0_0083);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h0E;
    step("mis");
    check("mis.pulse", 32'(bus.misalign_err), 32'd1);
    bus.redirect_valid = 1'b0;
    step("mis.tgt");
    check("mis.ins", bus.out_instr, 32'h0030_23b3);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hFC;
    step("wrap");
    bus.redirect_valid = 1'b0;
    step("wrap.fc");
    check("wrap.addr", 32'(bus.imem_addr), 32'h00);
    step("wrap.00");
    check("wrap.opc", 32'(bus.out_pc), 32'h00);

    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      bus.redirect_valid = 1'($urandom_range(0, 7) == 0);
      bus.redirect_pc = 8'($urandom);
      step("rand");
    end

    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    step("pre");
    bus.out_ready = 1'b0;
    step("hold");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare("arst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step("post");
    check("post.ins", bus.out_instr, 32'h0ff0_0083);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
